conv_bias_add: RTL and testbench
================================

CONV_BIAS_ADD -- requirements
Module: conv_bias_add

Interface
REQ-001 Parameter LANES, default 16: number of 32-bit accumulator lanes per beat; one beat carries one output channel.
REQ-002 Constant `M from incl.vh: output channels per W round.
REQ-003 clk  in  1  sole clock; all logic on posedge.
REQ-004 rstn  in  1  synchronous, active-low reset.
REQ-005 start_pulse  in  1  one-cycle start of a conv instruction.
REQ-006 n_X_rnd_minus_1, n_W_rnd_minus_1  in  16 each  round counts minus 1; sampled on start_pulse.
REQ-007 fifo_rd_en  out  1  Bias FIFO pop.
REQ-008 fifo_dout  in  64  bias word, valid 1 cycle after fifo_rd_en; [31:0] signed bias, [63:32] aux.
REQ-009 fifo_empty  in  1  Bias FIFO empty.
REQ-010 acc_vld  in  1, acc_rdy  out  1, acc_data  in  LANES*32  accumulator stream; lane i at [i*32+:32], signed.
REQ-011 out_vld  out  1, out_rdy  in  1, out_data  out  LANES*32, out_aux  out  32  biased result stream.
REQ-012 busy  out  1, done  out  1  status; done is a one-cycle pulse.

Function
REQ-013 Idle until start_pulse; start_pulse while busy=1 is ignored.
REQ-014 Total beats T = (n_X_rnd_minus_1+1)*(n_W_rnd_minus_1+1)*`M, tracked by nested m/w/x counters, not a multiply.
REQ-015 States: IDLE, RUN, DRAIN; IDLE->RUN on start_pulse; RUN->DRAIN when last input beat accepted; DRAIN->IDLE when last output beat handshaken.
REQ-016 Bias holding register with valid flag and a one-bit in-flight flag for the 1-cycle FIFO read latency.
REQ-017 fifo_rd_en=1 only in RUN, fifo_empty=0, fewer than T words popped, and holding register empty or being consumed this cycle with no read in flight.
REQ-018 Exactly T words popped per instruction; no pop beyond T even when the FIFO holds more.
REQ-019 acc_rdy = RUN && bias_valid && (~out_vld || out_rdy).
REQ-020 Input accept (acc_vld && acc_rdy) consumes one bias word and one beat.
REQ-021 Each lane: 32-bit signed accumulator plus bias[31:0], computed 33-bit, saturated to [-2^31, 2^31-1].
REQ-022 out_aux = bias[63:32] of the consumed word.
REQ-023 Latency: out_vld rises the cycle after accept.
REQ-024 out_data/out_aux hold stable while out_vld && ~out_rdy.
REQ-025 Full throughput: one beat per cycle when FIFO non-empty and out_rdy=1.
REQ-026 Output beat order equals input order, m fastest, then w, then x.
REQ-027 done pulses the cycle after the final output handshake; busy=0 in the same cycle.
REQ-028 Beats arriving in IDLE are not accepted (acc_rdy=0).

Reset
REQ-029 rstn=0 at posedge: state IDLE; all counters and flags cleared; fifo_rd_en, acc_rdy, out_vld, busy, done = 0; out_data, out_aux = 0.
REQ-030 Reset mid-instruction aborts it; a read in flight is discarded; no done pulse.

Structure
REQ-031 `M and the lane width (32) come from incl.vh; the bias word field positions are defined there as macros.
REQ-032 One sub-module, conv_bias_sat_add: a single-lane 32+32 signed saturating adder, instantiated LANES times.

Verification
REQ-033 n_X=0, n_W=0, `M beats, FIFO preloaded, out_rdy=1 -> `M outputs back-to-back, exactly `M pops, done one cycle after the last output.
REQ-034 acc 0x7FFFFFF0 + bias 0x20 -> 0x7FFFFFFF; acc 0x80000010 + bias 0xFFFFFFE0 -> 0x80000000; acc 5 + bias -7 -> 0xFFFFFFFE.
REQ-035 Random FIFO-empty gaps and out_rdy backpressure -> no loss or duplication, order per REQ-026, outputs stable while stalled.
REQ-036 FIFO preloaded with T+4 words -> exactly T pops; 4 words remain.
REQ-037 rstn low mid-RUN, then a new start -> clean restart, no done for the aborted instruction, correct second result.
REQ-038 start_pulse during RUN -> ignored; beat count unchanged.

Source files
------------

// File: rtl/conv_bias_add_pkg.sv
// Shared constants and types for the conv bias-add stage: channel count per W round,
// lane width and bias FIFO word layout.
package conv_bias_add_pkg;

  localparam int unsigned M         = 4;
  localparam int unsigned AccW      = 32;
  localparam int unsigned BiasWordW = 64;
  localparam int unsigned BiasLsb   = 0;
  localparam int unsigned AuxLsb    = 32;
  localparam int unsigned AuxW      = 32;

  localparam int unsigned MCntW = (M > 1) ? $clog2(M) : 1;
  localparam logic [MCntW-1:0] MLast = MCntW'(M - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

endpackage

// File: rtl/conv_bias_sat_add.sv
// Single-lane signed add of accumulator and bias, clamped to the 32-bit signed range.
module conv_bias_sat_add
  import conv_bias_add_pkg::*;
(
  input  logic [AccW-1:0] acc_i,
  input  logic [AccW-1:0] bias_i,
  output logic [AccW-1:0] sum_o
);

  logic [AccW:0] wide;

  assign wide = {acc_i[AccW-1], acc_i} + {bias_i[AccW-1], bias_i};

  // Top two bits disagree only on overflow; the carry-out bit gives the direction.
  always_comb begin
    sum_o = wide[AccW-1:0];
    if (wide[AccW] != wide[AccW-1]) begin
      sum_o = wide[AccW] ? {1'b1, {(AccW-1){1'b0}}} : {1'b0, {(AccW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/conv_bias_add.sv
// Adds one per-channel bias word from the bias FIFO to each accumulator beat of a conv
// instruction, saturating per lane, with a registered valid/ready output stage.
module conv_bias_add
  import conv_bias_add_pkg::*;
#(
  parameter int unsigned LANES = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_pulse,
  input  logic [15:0]             n_X_rnd_minus_1,
  input  logic [15:0]             n_W_rnd_minus_1,
  output logic                    fifo_rd_en,
  input  logic [BiasWordW-1:0]    fifo_dout,
  input  logic                    fifo_empty,
  input  logic                    acc_vld,
  output logic                    acc_rdy,
  input  logic [LANES*AccW-1:0]   acc_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [LANES*AccW-1:0]   out_data,
  output logic [AuxW-1:0]         out_aux,
  output logic                    busy,
  output logic                    done
);

  state_e                 state_q;
  logic [15:0]            nx_q, nw_q;
  logic [MCntW-1:0]       m_q, pm_q;
  logic [15:0]            w_q, x_q, pw_q, px_q;
  logic                   pop_done_q;
  logic [BiasWordW-1:0]   bias_q;
  logic                   bias_vld_q;
  logic                   inflight_q;
  logic                   out_vld_q;
  logic [LANES*AccW-1:0]  out_data_q;
  logic [AuxW-1:0]        out_aux_q;
  logic                   out_last_q;
  logic                   done_q;

  logic                   run;
  logic                   bias_avail;
  logic [BiasWordW-1:0]   bias_word;
  logic                   accept;
  logic                   out_fire;
  logic                   in_last;
  logic                   pop_last;
  logic [LANES*AccW-1:0]  sum;

  // The word of an in-flight read is used straight off the FIFO output, so a pop can be
  // issued every cycle the holding slot is consumed.
  assign run        = (state_q == StRun);
  assign bias_avail = bias_vld_q | inflight_q;
  assign bias_word  = inflight_q ? fifo_dout : bias_q;
  assign acc_rdy    = run && bias_avail && (!out_vld_q || out_rdy);
  assign accept     = acc_vld && acc_rdy;
  assign out_fire   = out_vld_q && out_rdy;
  assign fifo_rd_en = run && !fifo_empty && !pop_done_q && (!bias_avail || accept);

  assign in_last  = (m_q == MLast) && (w_q == nw_q) && (x_q == nx_q);
  assign pop_last = (pm_q == MLast) && (pw_q == nw_q) && (px_q == nx_q);

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_aux  = out_aux_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    conv_bias_sat_add u_sat (
      .acc_i  (acc_data[i*AccW +: AccW]),
      .bias_i (bias_word[BiasLsb +: AccW]),
      .sum_o  (sum[i*AccW +: AccW])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      nx_q       <= '0;
      nw_q       <= '0;
      m_q        <= '0;
      w_q        <= '0;
      x_q        <= '0;
      pm_q       <= '0;
      pw_q       <= '0;
      px_q       <= '0;
      pop_done_q <= 1'b0;
      bias_q     <= '0;
      bias_vld_q <= 1'b0;
      inflight_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_aux_q  <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= fifo_rd_en;

      if (accept) begin
        bias_vld_q <= 1'b0;
      end else if (inflight_q) begin
        bias_vld_q <= 1'b1;
        bias_q     <= fifo_dout;
      end

      if (accept) begin
        out_vld_q  <= 1'b1;
        out_data_q <= sum;
        out_aux_q  <= bias_word[AuxLsb +: AuxW];
        out_last_q <= in_last;
      end else if (out_rdy) begin
        out_vld_q <= 1'b0;
      end

      // Beat order: m fastest, then w, then x.
      if (accept) begin
        if (m_q == MLast) begin
          m_q <= '0;
          if (w_q == nw_q) begin
            w_q <= '0;
            x_q <= x_q + 16'd1;
          end else begin
            w_q <= w_q + 16'd1;
          end
        end else begin
          m_q <= m_q + 1'b1;
        end
      end

      if (fifo_rd_en) begin
        if (pop_last) pop_done_q <= 1'b1;
        if (pm_q == MLast) begin
          pm_q <= '0;
          if (pw_q == nw_q) begin
            pw_q <= '0;
            px_q <= px_q + 16'd1;
          end else begin
            pw_q <= pw_q + 16'd1;
          end
        end else begin
          pm_q <= pm_q + 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start_pulse) begin
            state_q    <= StRun;
            nx_q       <= n_X_rnd_minus_1;
            nw_q       <= n_W_rnd_minus_1;
            m_q        <= '0;
            w_q        <= '0;
            x_q        <= '0;
            pm_q       <= '0;
            pw_q       <= '0;
            px_q       <= '0;
            pop_done_q <= 1'b0;
          end
        end
        StRun: begin
          if (accept && in_last) state_q <= StDrain;
        end
        StDrain: begin
          if (out_fire && out_last_q) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bias_add.sv
// Directed bench for conv_bias_add: saturation vectors, throughput, pop count limits,
// backpressure/gaps, start-while-busy and mid-instruction reset.
module tb_conv_bias_add;
  import conv_bias_add_pkg::*;

  localparam int unsigned L  = 4;
  localparam int unsigned DW = L * 32;
  localparam int unsigned EW = DW + 32;

  typedef logic [DW-1:0] data_t;
  typedef logic [EW-1:0] exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start_pulse;
  logic [15:0]   n_x, n_w;
  logic          fifo_rd_en;
  logic [63:0]   fifo_dout;
  logic          fifo_empty;
  logic          acc_vld;
  logic          acc_rdy;
  data_t         acc_data;
  logic          out_vld;
  logic          out_rdy;
  data_t         out_data;
  logic [31:0]   out_aux;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  conv_bias_add #(.LANES(L)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start_pulse     (start_pulse),
    .n_X_rnd_minus_1 (n_x),
    .n_W_rnd_minus_1 (n_w),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_dout       (fifo_dout),
    .fifo_empty      (fifo_empty),
    .acc_vld         (acc_vld),
    .acc_rdy         (acc_rdy),
    .acc_data        (acc_data),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
    .out_data        (out_data),
    .out_aux         (out_aux),
    .busy            (busy),
    .done            (done)
  );

  data_t       acc_q[$];
  logic [63:0] fifo_q[$];
  exp_t        exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic busy_at_done = 1'b0;
  bit acc_gap_en = 0, fifo_gap_en = 0, bp_en = 0;
  bit acc_gap = 0, fifo_gap = 0;
  bit stall_prev = 0;
  exp_t held = '0;

  task automatic check(input string tag, input exp_t obs, input exp_t expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sat32(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (s < -64'sh80000000) return 32'h80000000;
    return s[31:0];
  endfunction

  task automatic refresh();
    acc_vld    = (acc_q.size() != 0) && !acc_gap;
    acc_data   = (acc_q.size() != 0) ? acc_q[0] : '0;
    fifo_empty = (fifo_q.size() == 0) || fifo_gap;
  endtask

  // Environment: FIFO with 1-cycle read latency, accumulator source, output scoreboard.
  initial begin
    bit   do_acc, do_pop, do_out;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      do_acc = acc_vld && acc_rdy;
      do_pop = fifo_rd_en;
      do_out = out_vld && out_rdy;
      if (do_pop) pop_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (stall_prev && out_vld) check("stall_hold", {out_aux, out_data}, held);
      stall_prev = out_vld && !out_rdy;
      held       = {out_aux, out_data};
      if (do_out) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        check("out_beat", {out_aux, out_data}, e);
        if (out_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        out_cnt++;
      end
      @(posedge clk);
      #1;
      if (do_acc && acc_q.size() != 0) void'(acc_q.pop_front());
      if (do_pop) fifo_dout = (fifo_q.size() != 0) ? fifo_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
      acc_gap  = acc_gap_en && ($urandom_range(0, 3) == 0);
      fifo_gap = fifo_gap_en && ($urandom_range(0, 2) == 0);
      out_rdy  = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      refresh();
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic add_exp(input data_t a, input logic [63:0] w, input data_t d);
    acc_q.push_back(a);
    fifo_q.push_back(w);
    exp_q.push_back({w[63:32], d});
  endtask

  task automatic add_rand(input int n);
    data_t a, d;
    logic [63:0] w;
    for (int k = 0; k < n; k++) begin
      w = {$urandom(), $urandom()};
      for (int i = 0; i < L; i++) begin
        a[i*32 +: 32] = $urandom();
        d[i*32 +: 32] = sat32(a[i*32 +: 32], w[31:0]);
      end
      add_exp(a, w, d);
    end
    refresh();
  endtask

  task automatic start(input int nx, input int nw);
    n_x         = 16'(nx);
    n_w         = 16'(nw);
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    check("done_seen", exp_t'(done_cnt), exp_t'(d0 + 1));
  endtask

  initial begin
    int d0;
    rstn        = 1'b0;
    start_pulse = 1'b0;
    n_x         = '0;
    n_w         = '0;
    fifo_dout   = '0;
    out_rdy     = 1'b1;
    refresh();
    step(3);
    check("rst_fifo_rd_en", exp_t'(fifo_rd_en), '0);
    check("rst_acc_rdy", exp_t'(acc_rdy), '0);
    check("rst_out_vld", exp_t'(out_vld), '0);
    check("rst_busy", exp_t'(busy), '0);
    check("rst_done", exp_t'(done), '0);
    check("rst_out_data", exp_t'(out_data), '0);
    check("rst_out_aux", exp_t'(out_aux), '0);
    rstn = 1'b1;
    step(2);

    // Saturation vectors, single W/X round, full throughput.
    add_exp({32'h7FFFFFDF, 32'hFFFFFFC0, 32'h00000001, 32'h7FFFFFF0}, {32'hA0, 32'h20},
            {32'h7FFFFFFF, 32'hFFFFFFE0, 32'h00000021, 32'h7FFFFFFF});
    add_exp({32'h7FFFFFFF, 32'h00000000, 32'h80000020, 32'h80000010},
            {32'hA1, 32'hFFFFFFE0},
            {32'h7FFFFFDF, 32'hFFFFFFE0, 32'h80000000, 32'h80000000});
    add_exp({32'h12345678, 32'h80000000, 32'h00000007, 32'h00000005},
            {32'hA2, 32'hFFFFFFF9},
            {32'h12345671, 32'h80000000, 32'h00000000, 32'hFFFFFFFE});
    add_exp({32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hDEADBEEF},
            {32'hFFFFFFFF, 32'h00000000},
            {32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hDEADBEEF});
    refresh();
    pop_cnt = 0;
    out_cnt = 0;
    step(3);
    check("idle_acc_rdy", exp_t'(acc_rdy), '0);
    check("idle_pops", exp_t'(pop_cnt), '0);
    start(0, 0);
    wait_done(60);
    check("t1_outs", exp_t'(out_cnt), exp_t'(M));
    check("t1_pops", exp_t'(pop_cnt), exp_t'(M));
    check("t1_b2b", exp_t'(last_cyc - first_cyc), exp_t'(M - 1));
    check("t1_done_lat", exp_t'(done_cyc), exp_t'(last_cyc + 1));
    check("t1_busy_at_done", exp_t'(busy_at_done), '0);
    step(2);

    // T+4 words in FIFO, backpressure, start pulse while busy.
    pop_cnt = 0;
    out_cnt = 0;
    bp_en      = 1;
    acc_gap_en = 1;
    add_rand(24);
    for (int k = 0; k < 4; k++) fifo_q.push_back({32'hEE, 32'(k)});
    refresh();
    start(1, 2);
    step(5);
    start(3, 3);
    wait_done(800);
    step(3);
    check("t2_outs", exp_t'(out_cnt), exp_t'(24));
    check("t2_pops", exp_t'(pop_cnt), exp_t'(24));
    check("t2_left", exp_t'(fifo_q.size()), exp_t'(4));
    check("t2_exp_left", exp_t'(exp_q.size()), '0);
    fifo_q.delete();
    bp_en      = 0;
    acc_gap_en = 0;
    refresh();
    step(2);

    // FIFO-empty gaps plus backpressure.
    pop_cnt = 0;
    out_cnt = 0;
    bp_en       = 1;
    fifo_gap_en = 1;
    acc_gap_en  = 1;
    add_rand(12);
    start(2, 0);
    wait_done(1000);
    check("t3_outs", exp_t'(out_cnt), exp_t'(12));
    check("t3_pops", exp_t'(pop_cnt), exp_t'(12));
    check("t3_exp_left", exp_t'(exp_q.size()), '0);
    bp_en       = 0;
    fifo_gap_en = 0;
    acc_gap_en  = 0;
    step(3);

    // Abort mid-run with reset, then a clean second instruction.
    add_rand(16);
    start(1, 1);
    step(8);
    d0   = done_cnt;
    rstn = 1'b0;
    step();
    acc_q.delete();
    fifo_q.delete();
    exp_q.delete();
    refresh();
    check("abort_busy", exp_t'(busy), '0);
    check("abort_out_vld", exp_t'(out_vld), '0);
    check("abort_acc_rdy", exp_t'(acc_rdy), '0);
    check("abort_fifo_rd_en", exp_t'(fifo_rd_en), '0);
    check("abort_out_data", exp_t'(out_data), '0);
    rstn = 1'b1;
    step(3);
    check("abort_no_done", exp_t'(done_cnt), exp_t'(d0));
    pop_cnt = 0;
    out_cnt = 0;
    add_rand(8);
    start(0, 1);
    wait_done(200);
    check("t4_outs", exp_t'(out_cnt), exp_t'(8));
    check("t4_pops", exp_t'(pop_cnt), exp_t'(8));
    check("t4_exp_left", exp_t'(exp_q.size()), '0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
